// File: rtl/fdivsqrt_seq_ctrl.sv
// Sequencer for the radix-2 divide/sqrt iteration datapath: accepts an operation, steps the
// digit-position vector once per iteration and holds the result valid until acknowledged.
module fdivsqrt_seq_ctrl #(
    parameter int unsigned DIVb = 64,
    parameter int unsigned CYCW = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FlushE,
    input  logic            StartE,
    input  logic            SqrtE,
    input  logic            SpecialCaseE,
    input  logic [CYCW-1:0] CyclesE,
    input  logic            HoldE,
    input  logic            ResultAck,
    output logic            InitE,
    output logic            IterEn,
    output logic [DIVb+1:0] C,
    output logic            BusyE,
    output logic            DoneM
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CYCW-1:0]   count_q, count_d;
    logic [DIVb+1:0]   c_q, c_d;
    logic              accept;
    logic              count_zero;

    localparam logic [DIVb+1:0] CDiv  = {2'b11, {DIVb{1'b0}}};
    localparam logic [DIVb+1:0] CSqrt = {3'b111, {(DIVb - 1){1'b0}}};

    assign count_zero = (count_q == '0);

    // Outputs are forced low while reset is held, even though state only clears at the edge.
    always_comb begin
        accept = StartE & ~FlushE & ~reset &
                 ((state_q == StIdle) | ((state_q == StDone) & ResultAck));
        InitE  = accept;
        IterEn = (state_q == StBusy) & ~HoldE & ~FlushE & ~reset;
        BusyE  = (state_q == StBusy) & ~reset;
        DoneM  = (state_q == StDone) & ~reset;
        C      = c_q;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        c_d     = c_q;
        if (FlushE) begin
            state_d = StIdle;
            count_d = '0;
        end else if (accept) begin
            c_d = SqrtE ? CSqrt : CDiv;
            if (SpecialCaseE) begin
                state_d = StDone;
                count_d = '0;
            end else begin
                state_d = StBusy;
                // A zero iteration request still runs one iteration.
                count_d = (CyclesE == '0) ? '0 : CyclesE - {{(CYCW - 1){1'b0}}, 1'b1};
            end
        end else begin
            unique case (state_q)
                StBusy: begin
                    if (IterEn) begin
                        c_d = {c_q[DIVb+1], c_q[DIVb+1:1]};
                        if (count_zero) begin
                            state_d = StDone;
                        end else begin
                            count_d = count_q - {{(CYCW - 1){1'b0}}, 1'b1};
                        end
                    end
                end
                StDone: begin
                    if (ResultAck) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            c_q     <= c_d;
        end
    end

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// Directed cycle-by-cycle vector table for fdivsqrt_seq_ctrl, plus a long-operation sequence.
module tb_fdivsqrt_seq_ctrl;

    localparam int unsigned DIVb = 8;
    localparam int unsigned CYCW = 7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            FlushE = 1'b0;
    logic            StartE = 1'b0;
    logic            SqrtE = 1'b0;
    logic            SpecialCaseE = 1'b0;
    logic [CYCW-1:0] CyclesE = '0;
    logic            HoldE = 1'b0;
    logic            ResultAck = 1'b0;
    logic            InitE;
    logic            IterEn;
    logic [DIVb+1:0] C;
    logic            BusyE;
    logic            DoneM;

    fdivsqrt_seq_ctrl #(.DIVb(DIVb), .CYCW(CYCW)) dut (
        .clk          (clk),
        .reset        (reset),
        .FlushE       (FlushE),
        .StartE       (StartE),
        .SqrtE        (SqrtE),
        .SpecialCaseE (SpecialCaseE),
        .CyclesE      (CyclesE),
        .HoldE        (HoldE),
        .ResultAck    (ResultAck),
        .InitE        (InitE),
        .IterEn       (IterEn),
        .C            (C),
        .BusyE        (BusyE),
        .DoneM        (DoneM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, fl, st, sq, sp;
        logic [6:0] cyc;
        logic       hd, ak;
        logic       e_init, e_iter, e_busy, e_done;
        logic       chk_c;
        logic [9:0] e_c;
    } vec_t;

    vec_t v[$];
    int   n_vec = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic rst, fl, st, sq, sp, input int cyc,
                                input logic hd, ak, ei, eit, eb, ed, chk, input int ec);
        vec_t r;
        r.rst = rst; r.fl = fl; r.st = st; r.sq = sq; r.sp = sp; r.cyc = 7'(cyc);
        r.hd = hd; r.ak = ak; r.e_init = ei; r.e_iter = eit; r.e_busy = eb; r.e_done = ed;
        r.chk_c = chk; r.e_c = 10'(ec);
        return r;
    endfunction

    task automatic drive(input vec_t r);
        reset = r.rst; FlushE = r.fl; StartE = r.st; SqrtE = r.sq; SpecialCaseE = r.sp;
        CyclesE = r.cyc; HoldE = r.hd; ResultAck = r.ak;
    endtask

    initial begin
        int iters;
        bit seen_done;
        //              rst fl st sq sp cyc hd ak | init iter busy done chk C
        v.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000)); // 0 reset beats start
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h000)); // 1 idle
        v.push_back(mk(0, 0, 1, 0, 0, 4, 0, 0, 1, 0, 0, 0, 1, 'h000)); // 2 div start 4
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h300));
        v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h380)); // start ignored in busy
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 'h3C0)); // ack ignored in busy
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h3E0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h3F0)); // 7 done, 6 ones
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h3F0)); // done held
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 'h3F0)); // ack
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h3F0)); // 10 idle
        v.push_back(mk(0, 0, 1, 0, 1, 10, 0, 0, 1, 0, 0, 0, 1, 'h3F0)); // special
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h300));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 'h300));
        v.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 1, 'h300)); // 14 div 3 with hold
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h300));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 'h380));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 'h380));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h380));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h3C0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h3E0)); // 20
        v.push_back(mk(0, 0, 1, 1, 0, 2, 0, 1, 1, 0, 0, 1, 1, 'h3E0)); // back-to-back sqrt
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h380));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h3C0));
        v.push_back(mk(0, 1, 1, 0, 0, 4, 0, 1, 0, 0, 0, 1, 1, 'h3E0)); // flush beats ack+start
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h3E0)); // 25
        v.push_back(mk(0, 0, 1, 0, 0, 8, 0, 0, 1, 0, 0, 0, 1, 'h3E0));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h300));
        v.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h380)); // flush at iter 2
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h380));
        v.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 'h380)); // 30 cycles=0
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h300));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h380));
        v.push_back(mk(0, 0, 1, 1, 1, 5, 0, 1, 1, 0, 0, 1, 1, 'h380)); // ack+special sqrt
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 'h380));
        v.push_back(mk(0, 0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1, 'h380)); // 35
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h300));
        v.push_back(mk(1, 0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 'h380)); // reset mid-busy
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h000));
        v.push_back(mk(0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 'h000)); // flush blocks start
        v.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 'h000)); // 40 start under hold
        v.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 'h300));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 'h300));
        v.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h380));

        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            drive(v[i]);
            #2;
            n_vec++;
            if (InitE !== v[i].e_init || IterEn !== v[i].e_iter || BusyE !== v[i].e_busy ||
                DoneM !== v[i].e_done || (v[i].chk_c && C !== v[i].e_c)) begin
                n_fail++;
                $display("FAIL row%0d: got init=%b iter=%b busy=%b done=%b C=%h, want %b %b %b %b C=%h",
                         i, InitE, IterEn, BusyE, DoneM, C, v[i].e_init, v[i].e_iter,
                         v[i].e_busy, v[i].e_done, v[i].e_c);
            end
        end

        // Long divide from DONE: ack+start, count iteration pulses until DoneM (bounded).
        @(negedge clk);
        reset = 0; FlushE = 0; StartE = 1; SqrtE = 0; SpecialCaseE = 0; CyclesE = 7'd20;
        HoldE = 0; ResultAck = 1;
        @(negedge clk);
        StartE = 0; ResultAck = 0; CyclesE = '0;
        iters = 0;
        seen_done = 0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            #2;
            if (DoneM === 1'b1) seen_done = 1;
            else begin
                if (IterEn === 1'b1) iters++;
                @(negedge clk);
            end
        end
        n_vec++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL long_done: DoneM never rose within 60 cycles, want DoneM=1");
        end
        n_vec++;
        if (iters != 20) begin
            n_fail++;
            $display("FAIL long_iters: got %0d IterEn pulses, want 20", iters);
        end
        n_vec++;
        if (C !== 10'h3FF) begin
            n_fail++;
            $display("FAIL long_c: got C=%h, want 3ff", C);
        end
        @(negedge clk);
        ResultAck = 1;
        @(negedge clk);
        ResultAck = 0;
        #2;
        n_vec++;
        if (DoneM !== 1'b0 || BusyE !== 1'b0) begin
            n_fail++;
            $display("FAIL long_ack: got done=%b busy=%b, want 0 0", DoneM, BusyE);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
